regfile_sb: RTL



---
 rtl/regfile_sb_if.sv | 27 ++
 rtl/regfile_sb.sv | 104 ++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, writeback port, scoreboard reservation and pending count.
// Master = decode/issue + writeback side, slave = the register file.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic [N_RD-1:0]        rd_busy;
    logic                   we;
    logic [ADDR_W-1:0]      wa;
    logic [DATA_W-1:0]      wd;
    logic                   res_en;
    logic [ADDR_W-1:0]      res_addr;
    logic [ADDR_W:0]        pend_cnt;

    modport master (
        output rd_addr, we, wa, wd, res_en, res_addr,
        input  rd_data, rd_busy, pend_cnt
    );

    modport slave (
        input  rd_addr, we, wa, wd, res_en, res_addr,
        output rd_data, rd_busy, pend_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending-bit scoreboard.
// Reads are registered (1-cycle latency); register 0 is hardwired to zero when ZERO_REG=1.
// Optional macro REGFILE_BYPASS_EN: read ports forward same-edge write data and
// report post-edge pending state; undefined, reads always see pre-edge state.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned N_RD     = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]      regs [DEPTH];
    logic [DEPTH-1:0]       pend_q;
    logic [DEPTH-1:0]       pend_c;
    logic [CNT_W-1:0]       cnt_c;
    logic [CNT_W-1:0]       pend_cnt_q;
    logic [N_RD*DATA_W-1:0] rd_data_q;
    logic [N_RD-1:0]        rd_busy_q;
    logic [DATA_W-1:0]      rdat_c [N_RD];
    logic [N_RD-1:0]        rbusy_c;
    logic                   wr_ok_c;
    logic                   res_ok_c;

    // Writes and reserves aimed at the hardwired zero register are dropped
    assign wr_ok_c  = bus.we     && !((ZERO_REG != 0) && (bus.wa == '0));
    assign res_ok_c = bus.res_en && !((ZERO_REG != 0) && (bus.res_addr == '0));

    // Next pending vector: write clears first, a same-cycle reserve (newer producer) wins
    always_comb begin
        pend_c = pend_q;
        if (wr_ok_c) begin
            pend_c[bus.wa] = 1'b0;
        end
        if (res_ok_c) begin
            pend_c[bus.res_addr] = 1'b1;
        end
    end

    // Popcount of the next pending vector, registered alongside the bits
    always_comb begin
        cnt_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_c = cnt_c + CNT_W'(pend_c[i]);
        end
    end

    // Per-port read selection
    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = bus.rd_addr[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rdat_c[g]  = (wr_ok_c && (bus.wa == ra)) ? bus.wd : regs[ra];
        assign rbusy_c[g] = pend_c[ra];
`else
        assign rdat_c[g]  = regs[ra];
        assign rbusy_c[g] = pend_q[ra];
`endif
    end

    // Register array write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok_c) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // Scoreboard bits and pending count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_c;
            pend_cnt_q <= cnt_c;
        end
    end

    // Registered read data and busy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_RD; i++) begin
                rd_data_q[i*DATA_W +: DATA_W] <= rdat_c[i];
            end
            rd_busy_q <= rbusy_c;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.pend_cnt = pend_cnt_q;
endmodule
